// File: rtl/imem_loader_if.sv
// Loader-side bundle for imem_loader: boot byte stream in, instruction-memory
// write port and boot status out. The loader connects through the slave modport.
interface imem_loader_if #(
  parameter int AW = 5
);
  logic          Start;
  logic [7:0]    InByte;
  logic          InValid;
  logic          InReady;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [31:0]   WrData;
  logic          Busy;
  logic          Done;
  logic          Error;
  logic          CpuHold;
  logic [2:0]    DbgState;

  modport master (
    output Start, InByte, InValid,
    input  InReady, WrEn, WrAddr, WrData, Busy, Done, Error, CpuHold, DbgState
  );

  modport slave (
    input  Start, InByte, InValid,
    output InReady, WrEn, WrAddr, WrData, Busy, Done, Error, CpuHold, DbgState
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian 32-bit words from a boot byte stream and writes
// them to instruction memory from address 0. Optional check byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int WORDS = 32,
  parameter int AW    = 5
) (
  input logic          Clk,
  input logic          Clrn,
  imem_loader_if.slave bus
);
  // Handshake: a byte transfers on a rising edge where InValid and InReady are both 1.
  // InReady is decoded from the FSM state only, so it never depends on InValid/InByte.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd4,
`endif
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  localparam logic [7:0] MAX_N = 8'(WORDS);

  state_t        state_q, state_d;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [AW:0]   n_q;
  logic [23:0]   asm_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif
  logic          in_ready, wr_en, busy, done, error, cpu_hold;
  logic          acc, count_bad, last_word;

  assign acc       = bus.InValid & in_ready;
  assign count_bad = (bus.InByte == 8'd0) || (bus.InByte > MAX_N);
  assign last_word = ({1'b0, word_idx} + (AW+1)'(1)) == n_q;

  always_ff @(posedge Clk) begin
    if (!Clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      IDLE: if (bus.Start) state_d = COUNT;
      COUNT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (acc) state_d = count_bad ? ERROR : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (acc && byte_idx == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (acc) state_d = (bus.InByte == xor_q) ? DONE : ERROR;
      end
`endif
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (bus.Start) state_d = COUNT;
      end
      ERROR: begin
        error = 1'b1;
        if (bus.Start) state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write address/data are captured with the 4th byte so WRITE drives registers only.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      word_idx  <= '0;
      byte_idx  <= '0;
      n_q       <= '0;
      asm_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      case (state_q)
        COUNT: if (acc) begin
          n_q      <= bus.InByte[AW:0];
          word_idx <= '0;
          byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_q    <= bus.InByte;  // fresh XOR for the session, seeded with the count
`endif
        end
        DATA: if (acc) begin
          asm_q    <= {asm_q[15:0], bus.InByte};
          byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_q    <= xor_q ^ bus.InByte;
`endif
          if (byte_idx == 2'd3) begin
            wr_addr_q <= word_idx;
            wr_data_q <= {asm_q, bus.InByte};
          end
        end
        WRITE: word_idx <= word_idx + AW'(1);
        default: ;
      endcase
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.WrEn     = wr_en;
  assign bus.WrAddr   = wr_addr_q;
  assign bus.WrData   = wr_data_q;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Error    = error;
  assign bus.CpuHold  = cpu_hold;
  assign bus.DbgState = state_q;
endmodule
